// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// over a shared memory port with a memready handshake. Optional bne support via MC_BNE_EN.
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4 into PC when memready
// DECODE  | read registers, branch target into ALUOut
// MEMADR  | compute lw/sw effective address
// MEMRD   | load data read, wait for memready
// MEMWB   | load data into rt
// MEMWR   | store write, strobe held until memready
// EXECUTE | R-type ALU operation
// ALUWB   | R-type result into rd
// BRANCH  | compare, conditionally load branch target
// ADDIEX  | addi ALU operation
// ADDIWB  | addi result into rt
// JUMP    | load jump target
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t     state_q, state_d, dec_state;
  logic       pcwrite, branch;
  logic [1:0] aluop;
`ifdef MC_BNE_EN
  logic       bne;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // While reset is high the outputs show the FETCH decode, whatever the register holds.
  assign dec_state = reset ? FETCH : state_q;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = memready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = memready ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = memready ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
`ifdef MC_BNE_EN
    bne      = 1'b0;
`endif
    case (dec_state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
`ifdef MC_BNE_EN
        bne     = (op == OP_BNE);
        branch  = (op != OP_BNE);
`else
        branch  = 1'b1;
`endif
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      branch   = 1'b0;
`ifdef MC_BNE_EN
      bne      = 1'b0;
`endif
    end
  end

`ifdef MC_BNE_EN
  assign pcen = pcwrite | (branch & zero) | (bne & ~zero);
`else
  assign pcen = pcwrite | (branch & zero);
`endif

  always_comb begin
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: per-cycle expected output vectors are queued as
// stimulus is driven and compared against sampled DUT outputs in each test task.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset, zero, memready;
  logic [5:0] op, funct;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];

  // {state, irwrite, pcen, regwrite, memwrite, iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, alucontrol}
  localparam logic [18:0] E_FETCH     = {4'd0,  4'b1100, 4'b0000, 2'b01, 2'b00, 3'b010};
  localparam logic [18:0] E_FWAIT     = {4'd0,  4'b0000, 4'b0000, 2'b01, 2'b00, 3'b010};
  localparam logic [18:0] E_RST       = {4'd0,  4'b0000, 4'b0000, 2'b01, 2'b00, 3'b010};
  localparam logic [18:0] E_RST_MEMRD = {4'd3,  4'b0000, 4'b0000, 2'b01, 2'b00, 3'b010};
  localparam logic [18:0] E_DECODE    = {4'd1,  4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010};
  localparam logic [18:0] E_MEMADR    = {4'd2,  4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010};
  localparam logic [18:0] E_MEMRD     = {4'd3,  4'b0000, 4'b1000, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] E_MEMWB     = {4'd4,  4'b0010, 4'b0100, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] E_MEMWR     = {4'd5,  4'b0001, 4'b1000, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] E_EXE_SLT   = {4'd6,  4'b0000, 4'b0001, 2'b00, 2'b00, 3'b111};
  localparam logic [18:0] E_EXE_AND   = {4'd6,  4'b0000, 4'b0001, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] E_ALUWB     = {4'd7,  4'b0010, 4'b0010, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] E_BR_T      = {4'd8,  4'b0100, 4'b0001, 2'b00, 2'b01, 3'b110};
  localparam logic [18:0] E_BR_N      = {4'd8,  4'b0000, 4'b0001, 2'b00, 2'b01, 3'b110};
  localparam logic [18:0] E_ADDIEX    = {4'd9,  4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010};
  localparam logic [18:0] E_ADDIWB    = {4'd10, 4'b0010, 4'b0000, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] E_JUMP      = {4'd11, 4'b0100, 4'b0000, 2'b00, 2'b10, 3'b010};

  mips_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .pcen       (pcen),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, state=%0d required run end", state);
    $fatal(1, "timeout");
  end

  // Called just after a rising edge: apply inputs, queue the expectation, sample mid-cycle.
  task automatic drive(input logic mr, input logic z, input logic [18:0] e);
    memready = mr;
    zero     = z;
    exp_q.push_back(e);
    @(negedge clk);
    obs_q.push_back({state, irwrite, pcen, regwrite, memwrite, iord, memtoreg, regdst,
                     alusrca, alusrcb, pcsrc, alucontrol});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] e, o;
    int i = 0;
    reset = 1'b1;
    op    = 6'b111111;
    drive(1'b1, 1'b0, E_RST);
    drive(1'b1, 1'b0, E_RST);
    reset = 1'b0;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset[%0d] got %b required %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_lw();
    logic [18:0] e, o;
    int i = 0;
    op = 6'b100011;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_MEMADR);
    drive(1'b1, 1'b0, E_MEMRD);
    drive(1'b1, 1'b0, E_MEMWB);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL lw[%0d] got %b required %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_rtype();
    logic [18:0] e, o;
    int i = 0;
    op    = 6'b000000;
    funct = 6'b101010;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_EXE_SLT);
    drive(1'b1, 1'b0, E_ALUWB);
    funct = 6'b100100;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_EXE_AND);
    drive(1'b1, 1'b0, E_ALUWB);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL rtype[%0d] got %b required %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_beq();
    logic [18:0] e, o;
    int i = 0;
    op = 6'b000100;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b1, E_BR_T);
    drive(1'b1, 1'b1, E_FETCH);
    drive(1'b1, 1'b1, E_DECODE);
    drive(1'b1, 1'b0, E_BR_N);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL beq[%0d] got %b required %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_addi_jump();
    logic [18:0] e, o;
    int i = 0;
    op = 6'b001000;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_ADDIEX);
    drive(1'b1, 1'b0, E_ADDIWB);
    op = 6'b000010;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_JUMP);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL addi_jump[%0d] got %b required %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_wait_states();
    logic [18:0] e, o;
    int i = 0;
    op = 6'b101011;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_MEMADR);
    drive(1'b0, 1'b0, E_MEMWR);
    drive(1'b0, 1'b0, E_MEMWR);
    drive(1'b0, 1'b0, E_MEMWR);
    drive(1'b1, 1'b0, E_MEMWR);
    op = 6'b111111;
    drive(1'b0, 1'b0, E_FWAIT);
    drive(1'b0, 1'b0, E_FWAIT);
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL wait_states[%0d] got %b required %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_bne();
    logic [18:0] e, o;
    int i = 0;
    op = 6'b000101;
`ifdef MC_BNE_EN
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_BR_T);
    drive(1'b1, 1'b1, E_FETCH);
    drive(1'b1, 1'b1, E_DECODE);
    drive(1'b1, 1'b1, E_BR_N);
`else
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
`endif
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL bne[%0d] got %b required %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] e, o;
    int i = 0;
    op = 6'b100011;
    drive(1'b1, 1'b0, E_FETCH);
    drive(1'b1, 1'b0, E_DECODE);
    drive(1'b1, 1'b0, E_MEMADR);
    drive(1'b0, 1'b0, E_MEMRD);
    reset = 1'b1;
    drive(1'b1, 1'b0, E_RST_MEMRD);
    reset = 1'b0;
    drive(1'b1, 1'b0, E_FETCH);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_mid[%0d] got %b required %b", i, o, e);
      end
      i++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    memready = 1'b1;
    zero     = 1'b0;
    op       = 6'b111111;
    funct    = 6'b000000;
    @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi_jump();
    test_wait_states();
    test_bne();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the MIPS core. It sequences a shared-memory, multicycle datapath, which is the next step from the single-cycle processor. It decodes the latched instruction's opcode and funct fields and steps through the fetch, decode, execute, memory and writeback states. In each state it drives the datapath multiplexer selects, register and PC write enables, memory strobes and ALU control. A memory-ready handshake lets instruction and data accesses through the single memory port take more than one cycle.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- memready  in  1  memory completes current access this cycle (tie 1 for zero-wait memory)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = data register
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation
- pcen  out  1  PC load enable
- state  out  4  current state, for debug and verification

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite = memready.
  - Stay in FETCH while memready=0; go to DECODE when memready=1.
- DECODE: alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other op → FETCH, with no architectural write
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold until memready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Then FETCH.
- MEMWR: iord=1, memwrite=1 held for the whole wait. Leave for FETCH when memready=1.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Then FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Then FETCH.
- JUMP: pcsrc=10, pcwrite=1. Then FETCH.
- Signals not listed for a state are 0.
- pcen = pcwrite | (branch & zero). This is combinational on the zero input.
- alucontrol:
  - aluop 00 → 010
  - aluop 01 → 110
  - aluop 10, by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other funct → 010
  - aluop 11 is unused → 010

## Timing
- Reset:
  - reset high at a rising edge loads state=FETCH.
  - While reset is high, irwrite, pcen, regwrite and memwrite are forced 0, regardless of state or memready.
  - All other outputs show the FETCH decode.
  - Reset mid-instruction abandons the instruction at the next edge; no partial writeback occurs after that edge.
- Cycles per instruction with memready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, undefined op 2.
- Each cycle memready is low in FETCH, MEMRD or MEMWR adds one cycle.
  - FETCH: PC and IR are not written until the cycle memready is high, so there is no double increment.
  - MEMWR: exactly one write is committed, in the memready=1 cycle. Memory samples memwrite&memready.
- State register updates only on the rising edge of clk. Outputs other than pcen, irwrite and pcwrite are pure functions of state and op/funct.

## Configuration
- MC_BNE_EN:
  - When defined: op 000101 (bne) decodes to the BRANCH state and asserts a branch-not-equal flag, and pcen = pcwrite | (branch & zero) | (bne & ~zero). bne takes 3 cycles.
  - When undefined: op 000101 is an undefined op (DECODE→FETCH) and no bne logic is built.

## Test plan
- Reset: hold reset 2 cycles with memready=1 → state=0; irwrite, pcen, regwrite and memwrite all 0; after release, FETCH asserts irwrite=1 and pcen=1.
- lw, op=100011, memready=1 → states 0,1,2,3,4,0; MEMWB has regwrite=1, memtoreg=1, regdst=0; memwrite never 1.
- R-type, op=0: funct=101010 → EXECUTE alucontrol=111; funct=100100 → 000; ALUWB has regwrite=1, regdst=1.
- beq, op=000100: zero=1 in BRANCH → pcen=1, pcsrc=01; zero=0 → pcen=0; each sequence is 0,1,8,0.
- Wait states, sw with memready low 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles and state=5 throughout, then FETCH. memready low 2 cycles in FETCH → irwrite=0 and pcen=0 for 2 cycles, then 1 for one cycle.
- Undefined op 111111 → 0,1,0 with no write strobe. Separately, reset asserted in MEMRD → state=0 next cycle, regwrite never asserted. With MC_BNE_EN, op 000101 and zero=0 → pcen=1 in BRANCH.
